fc_classifier: RTL and testbench

Fully connected output stage of the 1-D CNN ECG accelerator: receiver and responder for the feature stream that the main controller drives during its fully connected phase. Accepts the 64 flattened 8-bit layer-4 features as 16 beats of 4 lanes and multiply-accumulates them against a 4×64 signed weight ROM plus per-class bias. Resolves the winning class by argmax and returns it with a one-cycle completion pulse that the controller uses to enter its classifier state.

---
 rtl/fc_pkg.sv | 42 ++++
 rtl/fc_weight_rom.sv | 40 ++++
 rtl/fc_classifier.sv | 113 +++++++++++
 tb/tb_fc_classifier.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared constants, state encoding and arithmetic types for the
// fully connected classifier stage.
package fc_pkg;

    localparam int unsigned N_FEAT  = 64;
    localparam int unsigned LANES   = 4;
    localparam int unsigned BEATS   = N_FEAT / LANES;
    localparam int unsigned N_CLASS = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned ACCW    = 24;

    localparam int unsigned BEAT_W  = $clog2(BEATS);
    localparam int unsigned CLASS_W = $clog2(N_CLASS);
    localparam int unsigned WADDR_W = $clog2(N_CLASS * N_FEAT);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        ARGMAX
    } state_t;

    typedef logic signed [DW-1:0]   feat_t;
    typedef logic signed [ACCW-1:0] acc_t;

    // Dot product of one beat's lanes with one class's weights. Each 16-bit
    // signed product is sign-extended before summing, so no lane can wrap.
    function automatic acc_t lane_dot(input logic [LANES-1:0][DW-1:0] x,
                                      input logic [LANES-1:0][DW-1:0] w);
        acc_t                     sum;
        logic signed [2*DW-1:0]   prod;
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            prod = feat_t'(x[l]) * feat_t'(w[l]);
            sum  = sum + acc_t'(prod);
        end
        return sum;
    endfunction

endpackage

// File: rtl/fc_weight_rom.sv
// fc_weight_rom: class-major weight ROM (index c*N_FEAT+f) and per-class bias
// table. Read is combinational on the beat index, so the weights line up with
// the beat sampled on the same edge.
module fc_weight_rom
    import fc_pkg::*;
#(
    parameter string                        WEIGHT_FILE = "fc_weights.mem",
    parameter string                        BIAS_FILE   = "fc_bias.mem",
    parameter logic [N_CLASS*N_FEAT*DW-1:0] W_INIT      = '0,
    parameter logic [N_CLASS*ACCW-1:0]      B_INIT      = '0
) (
    input  logic [BEAT_W-1:0]                   beat,
    output logic [N_CLASS-1:0][LANES-1:0][DW-1:0] weights,
    output logic [N_CLASS-1:0][ACCW-1:0]          bias
);

    logic [DW-1:0]   w_mem [N_CLASS*N_FEAT];
    logic [ACCW-1:0] b_mem [N_CLASS];

    // Load the weight and bias images from the parameters.
    initial begin
        for (int i = 0; i < N_CLASS * N_FEAT; i++) begin
            w_mem[i] = W_INIT[i*DW +: DW];
        end
        for (int c = 0; c < N_CLASS; c++) begin
            b_mem[c] = B_INIT[c*ACCW +: ACCW];
        end
    end

    // Present the LANES weights of every class for the current beat.
    always_comb begin
        for (int c = 0; c < N_CLASS; c++) begin
            for (int l = 0; l < LANES; l++) begin
                weights[c][l] = w_mem[WADDR_W'(c * N_FEAT + int'(beat) * LANES + l)];
            end
            bias[c] = b_mem[CLASS_W'(c)];
        end
    end

endmodule

// File: rtl/fc_classifier.sv
// fc_classifier: receives 16 beats of 4 signed features, accumulates them
// against the weight ROM for all classes in parallel, adds bias, and reports
// the argmax class with a one-cycle fc_done pulse.
module fc_classifier
    import fc_pkg::*;
#(
    parameter string                        WEIGHT_FILE = "fc_weights.mem",
    parameter string                        BIAS_FILE   = "fc_bias.mem",
    parameter logic [N_CLASS*N_FEAT*DW-1:0] W_INIT      = '0,
    parameter logic [N_CLASS*ACCW-1:0]      B_INIT      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [LANES-1:0][DW-1:0] in,
    output logic [CLASS_W-1:0]       outfin,
    output logic                     fc_done
);

    state_t                               state;
    logic [BEAT_W-1:0]                    beat;
    acc_t                                 acc [N_CLASS];
    acc_t                                 dot [N_CLASS];
    logic [N_CLASS-1:0][LANES-1:0][DW-1:0] rom_w;
    logic [N_CLASS-1:0][ACCW-1:0]          rom_b;
    logic [CLASS_W-1:0]                   best_idx;
    acc_t                                 best_val;

    fc_weight_rom #(
        .WEIGHT_FILE (WEIGHT_FILE),
        .BIAS_FILE   (BIAS_FILE),
        .W_INIT      (W_INIT),
        .B_INIT      (B_INIT)
    ) u_rom (
        .beat    (beat),
        .weights (rom_w),
        .bias    (rom_b)
    );

    // One beat's contribution to each class: 4 classes x 4 lanes of MACs.
    always_comb begin
        for (int c = 0; c < N_CLASS; c++) begin
            dot[c] = lane_dot(in, rom_w[c]);
        end
    end

    // Strict greater-than scan from class 0, so ties go to the lowest index.
    always_comb begin
        best_idx = '0;
        best_val = acc[0];
        for (int c = 1; c < N_CLASS; c++) begin
            if (acc[c] > best_val) begin
                best_val = acc[c];
                best_idx = CLASS_W'(c);
            end
        end
    end

    // Frame sequencer: accumulate 16 beats, add bias, register the argmax.
    // Beat 0 overwrites the accumulators, so no clear cycle is needed and a
    // new frame may start on the edge where fc_done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            beat    <= '0;
            outfin  <= '0;
            fc_done <= 1'b0;
            for (int c = 0; c < N_CLASS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            fc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        for (int c = 0; c < N_CLASS; c++) begin
                            acc[c] <= dot[c];
                        end
                        beat  <= BEAT_W'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (en) begin
                        for (int c = 0; c < N_CLASS; c++) begin
                            acc[c] <= acc[c] + dot[c];
                        end
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= BIAS;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                // en is ignored here and in ARGMAX; such beats are dropped.
                BIAS: begin
                    for (int c = 0; c < N_CLASS; c++) begin
                        acc[c] <= acc[c] + acc_t'(rom_b[c]);
                    end
                    state <= ARGMAX;
                end
                ARGMAX: begin
                    outfin  <= best_idx;
                    fc_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_classifier.sv
// tb_fc_classifier: four classifier instances with different weight images
// share one feature stream. Expected classes come from a table of
// hand-derived constants and from an integer dot-product reference model.
module tb_fc_classifier;
    import fc_pkg::*;

    localparam int ND = 4;  // 0: W[2]=1, 1: all equal, 2: W[1]=-128, 3: pseudo-random

    function automatic logic [N_CLASS*N_FEAT*DW-1:0] mk_w(input int mode);
        logic [N_CLASS*N_FEAT*DW-1:0] v;
        int unsigned s;
        int w;
        v = '0;
        s = 32'h2468_ace1;
        for (int c = 0; c < N_CLASS; c++) begin
            for (int f = 0; f < N_FEAT; f++) begin
                s = s * 32'd1664525 + 32'd1013904223;
                case (mode)
                    0:       w = (c == 2) ? 1 : 0;
                    1:       w = 7;
                    2:       w = (c == 1) ? -128 : 0;
                    default: w = int'(s >> 24) - 128;
                endcase
                v[(c*N_FEAT+f)*DW +: DW] = DW'(w);
            end
        end
        return v;
    endfunction

    function automatic logic [N_CLASS*ACCW-1:0] mk_b(input int mode);
        logic [N_CLASS*ACCW-1:0] v;
        int unsigned s;
        int b;
        v = '0;
        s = 32'h1357_9bdf;
        for (int c = 0; c < N_CLASS; c++) begin
            s = s * 32'd1664525 + 32'd1013904223;
            case (mode)
                1:       b = 100;
                3:       b = int'(s >> 14) - 131072;
                default: b = 0;
            endcase
            v[c*ACCW +: ACCW] = ACCW'(b);
        end
        return v;
    endfunction

    // Reference: plain integer sums over all 64 features plus bias, then
    // first-maximum argmax.
    function automatic int model_class(input int d, input int feats [N_FEAT]);
        logic [N_CLASS*N_FEAT*DW-1:0] wv;
        logic [N_CLASS*ACCW-1:0] bv;
        int s [N_CLASS];
        int bi;
        wv = mk_w(d);
        bv = mk_b(d);
        for (int c = 0; c < N_CLASS; c++) begin
            s[c] = int'($signed(bv[c*ACCW +: ACCW]));
            for (int f = 0; f < N_FEAT; f++) begin
                s[c] += int'($signed(wv[(c*N_FEAT+f)*DW +: DW])) * feats[f];
            end
        end
        bi = 0;
        for (int c = 1; c < N_CLASS; c++) begin
            if (s[c] > s[bi]) bi = c;
        end
        return bi;
    endfunction

    logic                     clk;
    logic                     rst;
    logic                     en;
    logic [LANES-1:0][DW-1:0] din;
    logic [CLASS_W-1:0]       outfin [ND];
    logic                     done   [ND];

    int checks;
    int failures;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        fc_classifier #(
            .WEIGHT_FILE (""),
            .BIAS_FILE   (""),
            .W_INIT      (mk_w(g)),
            .B_INIT      (mk_b(g))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .in      (din),
            .outfin  (outfin[g]),
            .fc_done (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_done(input int exp, input string nm);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s dut%0d fc_done", nm, d), int'(done[d]), exp);
        end
    endtask

    task automatic chk_out(input int exp [ND], input string nm);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s dut%0d outfin", nm, d), int'(outfin[d]), exp[d]);
        end
    endtask

    task automatic set_beat(input int feats [N_FEAT], input int b);
        en = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            din[l] = DW'(feats[b*LANES+l]);
        end
    endtask

    // Drive beats first..last on consecutive negedges, optionally with idle
    // cycles after beat gap_at and/or random idle cycles between beats.
    task automatic drive_beats(input int feats [N_FEAT], input int first, input int last,
                               input int gap_at, input int gap_len, input bit rnd);
        for (int b = first; b <= last; b++) begin
            @(negedge clk);
            set_beat(feats, b);
            if (b != BEATS - 1) begin
                int n;
                n = (b == gap_at) ? gap_len : 0;
                if (rnd) n += int'($urandom_range(0, 2));
                for (int g = 0; g < n; g++) begin
                    @(negedge clk);
                    en  = 1'b0;
                    din = $urandom;
                end
            end
        end
    endtask

    // Last beat was sampled on edge E: fc_done must be low after E and E+1,
    // high after E+2 with the new class, and low again after E+3.
    task automatic check_tail(input int exp [ND], input string nm);
        @(negedge clk);
        en = 1'b0;
        chk_done(0, {nm, " E+0"});
        @(negedge clk);
        chk_done(0, {nm, " E+1"});
        @(negedge clk);
        chk_done(1, {nm, " E+2"});
        chk_out(exp, nm);
        @(negedge clk);
        chk_done(0, {nm, " E+3"});
    endtask

    typedef struct {
        int fill;
        int gap_at;
        int gap_len;
        int exp_a;
        int exp_b;
        int exp_c;
    } vec_t;

    vec_t tbl [6];
    int   feats [N_FEAT];
    int   f2 [N_FEAT];
    int   exp [ND];
    int   exp2 [ND];

    initial begin
        checks   = 0;
        failures = 0;
        en       = 1'b0;
        din      = '0;
        rst      = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_done(0, "reset");
        exp = '{0, 0, 0, 0};
        chk_out(exp, "reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // fill, gap after beat, gap length, class for W[2]=1 / equal / W[1]=-128
        tbl[0] = '{1,    -1, 0, 2, 0, 0};
        tbl[1] = '{1,     5, 3, 2, 0, 0};
        tbl[2] = '{-128, -1, 0, 0, 0, 1};
        tbl[3] = '{-1,    2, 1, 0, 0, 1};
        tbl[4] = '{0,    -1, 0, 0, 0, 0};
        tbl[5] = '{5,     0, 2, 2, 0, 0};

        for (int t = 0; t < 6; t++) begin
            for (int f = 0; f < N_FEAT; f++) feats[f] = tbl[t].fill;
            exp[0] = tbl[t].exp_a;
            exp[1] = tbl[t].exp_b;
            exp[2] = tbl[t].exp_c;
            exp[3] = model_class(3, feats);
            drive_beats(feats, 0, BEATS - 1, tbl[t].gap_at, tbl[t].gap_len, 1'b0);
            check_tail(exp, $sformatf("vec%0d", t));
        end

        // Reset after beat 9 of a large-magnitude frame, then a clean frame.
        for (int f = 0; f < N_FEAT; f++) feats[f] = -128;
        drive_beats(feats, 0, 9, -1, 0, 1'b0);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        #1;
        chk_done(0, "mid_rst");
        exp = '{0, 0, 0, 0};
        chk_out(exp, "mid_rst");
        @(negedge clk);
        rst = 1'b1;
        for (int f = 0; f < N_FEAT; f++) feats[f] = 1;
        exp = '{2, 0, 0, 0};
        exp[3] = model_class(3, feats);
        drive_beats(feats, 0, BEATS - 1, -1, 0, 1'b0);
        check_tail(exp, "after_rst");

        // Back-to-back: en held high through BIAS/ARGMAX, frame 2 beat 0 on
        // the edge where fc_done is high.
        for (int f = 0; f < N_FEAT; f++) begin
            feats[f] = 1;
            f2[f]    = -1;
        end
        exp    = '{2, 0, 0, 0};
        exp[3] = model_class(3, feats);
        exp2   = '{0, 0, 1, 0};
        exp2[3] = model_class(3, f2);
        drive_beats(feats, 0, BEATS - 1, -1, 0, 1'b0);
        @(negedge clk);
        en  = 1'b1;
        din = $urandom;
        chk_done(0, "b2b E+0");
        @(negedge clk);
        en  = 1'b1;
        din = $urandom;
        chk_done(0, "b2b E+1");
        @(negedge clk);
        chk_done(1, "b2b E+2");
        chk_out(exp, "b2b frame1");
        set_beat(f2, 0);
        @(negedge clk);
        chk_done(0, "b2b E+3");
        set_beat(f2, 1);
        drive_beats(f2, 2, BEATS - 1, -1, 0, 1'b0);
        check_tail(exp2, "b2b frame2");

        // Random features with random inter-beat gaps against the model.
        for (int r = 0; r < 8; r++) begin
            for (int f = 0; f < N_FEAT; f++) feats[f] = int'($urandom_range(0, 255)) - 128;
            for (int d = 0; d < ND; d++) exp[d] = model_class(d, feats);
            drive_beats(feats, 0, BEATS - 1, -1, 0, 1'b1);
            check_tail(exp, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
